// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and frame constants for the UART TX/RX paths.
// Optional feature macro: UART_PARITY_EN (even parity bit between data bit 7 and stop).
package uart_pkg;

  // One encoding serves both FSMs; PARITY is only reached when UART_PARITY_EN is defined.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int   DATA_BITS  = 8;
  localparam int   BIT_IDX_W  = $clog2(DATA_BITS);
  localparam logic IDLE_LEVEL = 1'b1;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_if.sv
// uart_if: byte-level host handshake between host logic and uart_core.
// Serial pad signals (tx/rx) are plain ports on the core so loopback is a single wire.
// Optional feature macro: UART_PARITY_EN (does not change this interface).
interface uart_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] tx_data;
  logic                 start;
  logic                 tx_busy;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_done;
  logic                 frame_err;

  // Host side: issues bytes, consumes received bytes.
  modport master (
    output tx_data, start,
    input  tx_busy, rx_data, rx_done, frame_err
  );

  // Core side.
  modport slave (
    input  tx_data, start,
    output tx_busy, rx_data, rx_done, frame_err
  );
endinterface

// File: rtl/uart_rx_unit.sv
// uart_rx_unit: rx synchronizer, receive FSM and bit/sample counters.
// Samples each bit at its midpoint, found by waiting half a bit after the start edge.
// Optional feature macro: UART_PARITY_EN (adds a PARITY state checking even parity).
module uart_rx_unit
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434  // must be >= 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 frame_err
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_IDX_W-1:0] IDX_LAST = BIT_IDX_W'(DATA_BITS - 1);

  logic                 rx_meta_q, rx_sync_q;
  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BIT_IDX_W-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 par_ok;
`ifdef UART_PARITY_EN
  logic                 par_q, par_d;
`endif

  // Two-flop synchronizer; resets to the idle level so reset never looks like a start bit.
  // NOTE: rx is asynchronous to clk; only rx_sync_q may feed logic, never rx or rx_meta_q.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      rx_meta_q <= IDLE_LEVEL;
      rx_sync_q <= IDLE_LEVEL;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Next-state, counter, shift and output-pulse logic of the receive FSM.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    par_ok  = 1'b1;
`ifdef UART_PARITY_EN
    par_d   = par_q;
    par_ok  = (par_q == even_parity(shift_q));
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_sync_q != IDLE_LEVEL) state_d = START;
      end
      START: begin
        // Half a bit in: still low means a real start bit, otherwise a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = (rx_sync_q == IDLE_LEVEL) ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
          if (bit_q == IDX_LAST) begin
`ifdef UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          par_d   = rx_sync_q;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_sync_q == IDLE_LEVEL && par_ok) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Receive FSM state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign rx_data   = data_q;
  assign rx_done   = done_q;
  assign frame_err = err_q;

endmodule

// File: rtl/uart_core.sv
// uart_core: 8N1 UART transmitter (inline) plus receiver (uart_rx_unit), one clock/reset.
// tx is registered, so it goes low the cycle after start is accepted.
// Optional feature macro: UART_PARITY_EN (even parity bit on TX and RX, frame grows by one bit).
module uart_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434  // clocks per bit, must be >= 4
) (
  input  logic  clk,
  input  logic  rst,
  uart_if.slave host,
  output logic  tx,
  input  logic  rx
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BIT_IDX_W-1:0] IDX_LAST = BIT_IDX_W'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BIT_IDX_W-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
`ifdef UART_PARITY_EN
  logic                 par_q, par_d;
`endif

  logic [DATA_BITS-1:0] rx_data_w;
  logic                 rx_done_w, frame_err_w;

  // Transmit FSM: next state, line level and shift register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
`ifdef UART_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        tx_d  = IDLE_LEVEL;
        // Byte is captured here; later tx_data changes cannot touch the frame.
        if (host.start) begin
          shift_d = host.tx_data;
`ifdef UART_PARITY_EN
          par_d   = even_parity(host.tx_data);
`endif
          busy_d  = 1'b1;
          tx_d    = ~IDLE_LEVEL;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (bit_q == IDX_LAST) begin
`ifdef UART_PARITY_EN
            tx_d    = par_q;
            state_d = PARITY;
`else
            tx_d    = IDLE_LEVEL;
            state_d = STOP;
`endif
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          tx_d    = IDLE_LEVEL;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        // busy drops with the move to IDLE; a start seen on this last cycle is ignored.
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        tx_d    = IDLE_LEVEL;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Transmit FSM registers; reset wins over any start, including mid-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= IDLE_LEVEL;
      busy_q  <= 1'b0;
`ifdef UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
`ifdef UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx           = tx_q;
  assign host.tx_busy = busy_q;

  uart_rx_unit #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data_w),
    .rx_done   (rx_done_w),
    .frame_err (frame_err_w)
  );

  assign host.rx_data   = rx_data_w;
  assign host.rx_done   = rx_done_w;
  assign host.frame_err = frame_err_w;

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: loopback bench for uart_core with CLKS_PER_BIT=16 and a 20 ns clock.
// Works with or without UART_PARITY_EN.
module tb_uart_core;

  localparam int N = 16;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
  localparam int PAR_EXTRA = N;
`else
  localparam int NB = 10;
  localparam int PAR_EXTRA = 0;
`endif
  // start-sampling edge to the edge that raises rx_done
  localparam int LAT_NOM = 9 * N + N / 2 + 4 + PAR_EXTRA;
  localparam int LAT_MIN = LAT_NOM - 1;
  localparam int LAT_MAX = LAT_NOM + 1;

  typedef struct {
    logic [7:0] data;
    int         glitch;  // frame bit index at which a stray start is pulsed, -1 for none
    logic [7:0] exp_rx;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;
  logic loop_en = 1'b1;
  logic force_rx = 1'b1;
  logic rx_line;

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_seen = 0;
  int err_seen = 0;
  logic [7:0] exp_q[$];
  int start_cyc_q[$];

  uart_if host();

  assign rx_line = loop_en ? tx : force_rx;

  uart_core #(.CLKS_PER_BIT(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .host (host),
    .tx   (tx),
    .rx   (rx_line)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected line level for bit i of a frame carrying d.
  function automatic logic frame_bit(input logic [7:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
`ifdef UART_PARITY_EN
    if (i == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Scoreboard consumer: every rx_done must match the oldest pending byte.
  always @(negedge clk) begin
    if (!rst) begin
      if (host.rx_done || host.frame_err)
        check("done_err_exclusive", 32'(host.rx_done & host.frame_err), 0);
      if (host.frame_err) err_seen++;
      if (host.rx_done) begin
        done_seen++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_rx_done: got rx_data=%0h, want no pulse (cycle %0d)",
                   host.rx_data, cyc);
        end else begin
          automatic logic [7:0] e = exp_q.pop_front();
          automatic int sc = start_cyc_q.pop_front();
          check("rx_data", host.rx_data, e);
          if (sc >= 0) begin
            automatic int lat = cyc - sc;
            check("latency", (lat >= LAT_MIN && lat <= LAT_MAX) ? LAT_NOM : lat, LAT_NOM);
          end
        end
      end
    end
  end

  // Issue one byte from a negedge, checking every bit mid-period; returns at the
  // negedge of the first IDLE cycle so a following call is back-to-back.
  task automatic send(input logic [7:0] d, input int glitch_bit, input logic [7:0] exp_rx);
    host.tx_data = d;
    host.start   = 1'b1;
    @(posedge clk);
    #1;
    host.start   = 1'b0;
    host.tx_data = ~d;
    exp_q.push_back(exp_rx);
    start_cyc_q.push_back(cyc);
    check("tx_busy_after_start", host.tx_busy, 1);
    for (int b = 0; b < NB; b++) begin
      repeat (N / 2) @(posedge clk);
      @(negedge clk);
      check($sformatf("tx_bit%0d_of_%0h", b, d), tx, frame_bit(d, b));
      check("tx_busy_mid_frame", host.tx_busy, 1);
      if (b == glitch_bit) begin
        host.tx_data = 8'h3C;
        host.start   = 1'b1;
        @(posedge clk);
        #1;
        host.start   = 1'b0;
        repeat (N - N / 2 - 1) @(posedge clk);
      end else begin
        repeat (N - N / 2) @(posedge clk);
      end
    end
    @(negedge clk);
    check("tx_busy_idle_gap", host.tx_busy, 0);
    check("tx_idle_level", tx, 1);
  endtask

  // Bit-bang a frame onto rx with loopback broken; stop_val chooses the stop level.
  task automatic drive_frame(input logic [7:0] d, input logic stop_val);
    for (int i = 0; i < NB; i++) begin
      force_rx = (i == NB - 1) ? stop_val : frame_bit(d, i);
      repeat (N) @(negedge clk);
    end
    force_rx = 1'b1;
    repeat (3 * N) @(negedge clk);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 * N && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    vec_t vecs[5];
    vecs[0] = '{8'hA5, -1, 8'hA5};
    vecs[1] = '{8'h00, -1, 8'h00};
    vecs[2] = '{8'hFF, -1, 8'hFF};
    vecs[3] = '{8'h81,  3, 8'h81};
    vecs[4] = '{8'h5A, -1, 8'h5A};

    host.start   = 1'bx;
    host.tx_data = 8'h00;

    // Reset held for 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_tx_busy", host.tx_busy, 0);
      check("rst_rx_data", host.rx_data, 8'h00);
      check("rst_rx_done", host.rx_done, 0);
    end
    host.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_tx", tx, 1);

    // Loopback table, issued back-to-back (includes 00 then FF and a stray start on 81)
    for (int v = 0; v < 5; v++) send(vecs[v].data, vecs[v].glitch, vecs[v].exp_rx);
    wait_drain();
    repeat (12 * N) @(negedge clk);
    check("frames_received", done_seen, 5);
    check("no_frame_err_loopback", err_seen, 0);
    check("rx_data_last", host.rx_data, vecs[4].exp_rx);
    check("tx_quiet_after_stray_start", {host.tx_busy, tx}, 2'b01);

    // False start: low for 5 cycles only
    loop_en  = 1'b0;
    force_rx = 1'b0;
    repeat (5) @(negedge clk);
    force_rx = 1'b1;
    repeat (2 * N) @(negedge clk);
    check("false_start_no_done", done_seen, 5);
    check("false_start_no_err", err_seen, 0);

    // 55 with stop bit forced low
    drive_frame(8'h55, 1'b0);
    check("bad_stop_err_pulses", err_seen, 1);
    check("bad_stop_no_done", done_seen, 5);
    check("bad_stop_rx_data_kept", host.rx_data, 8'h5A);

    // A clean bit-banged frame shows the receiver recovered to IDLE
    exp_q.push_back(8'hC3);
    start_cyc_q.push_back(-1);
    drive_frame(8'hC3, 1'b1);
    wait_drain();
    check("recovered_rx_data", host.rx_data, 8'hC3);

    // Reset in the middle of a loopback frame
    loop_en      = 1'b1;
    host.tx_data = 8'h96;
    host.start   = 1'b1;
    @(posedge clk);
    #1;
    host.start   = 1'b0;
    repeat (3 * N) @(negedge clk);
    check("pre_rst_busy", host.tx_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx", tx, 1);
    check("midrst_tx_busy", host.tx_busy, 0);
    check("midrst_rx_data", host.rx_data, 8'h00);
    check("midrst_rx_done", host.rx_done, 0);
    check("midrst_frame_err", host.frame_err, 0);
    rst = 1'b0;
    repeat (12 * N) @(negedge clk);
    check("aborted_frame_no_done", done_seen, 6);

    // Normal operation after reset
    send(8'h69, -1, 8'h69);
    wait_drain();
    check("final_done_count", done_seen, 7);
    check("final_err_count", err_seen, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- 8N1 UART transmitter and receiver in one block, sharing one clock and one reset.
- TX serialises a byte on a one-cycle start pulse.
- RX deserialises the rx line and pulses done once per valid frame.
- Sits between the byte-level host logic and the pad; top-level tests connect tx to rx externally for loopback.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit period (50 MHz / 115200); must be >= 4.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- tx_data  input  8  byte to transmit; sampled when start is accepted
- start  input  1  one-cycle transmit request
- tx  output  1  serial output, idle high
- tx_busy  output  1  high while a frame is being sent
- rx  input  1  serial input, asynchronous to clk
- rx_data  output  8  last correctly received byte
- rx_done  output  1  one-cycle pulse: rx_data is newly valid
- frame_err  output  1  one-cycle pulse: stop bit sampled low

Behaviour:
- Reset (rst sampled high): tx=1, tx_busy=0, rx_data=0, rx_done=0, frame_err=0, both FSMs in IDLE, counters 0.
- Reset overrides everything, including mid-frame; unknown start during reset is ignored.
- Frame format: start bit 0, data bits 0..7 LSB first, stop bit 1. Each bit lasts exactly CLKS_PER_BIT cycles.

TX FSM (IDLE, START, DATA, STOP):
- IDLE: tx=1. If start=1, latch tx_data into a shift register, set tx_busy=1, go to START.
- tx drives 0 from the cycle after start is sampled.
- START → DATA after CLKS_PER_BIT cycles.
- DATA: output shift[0]; shift right after each bit; go to STOP after 8 bits.
- STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE with tx_busy=0.
- start while busy is ignored (no queueing). start in the same cycle busy drops is still ignored; it is accepted on the next IDLE cycle.
- tx_data changes after acceptance do not affect the frame.

RX input conditioning:
- rx passes through a 2-flop synchronizer; all RX logic uses the synchronized signal.

RX FSM (IDLE, START, DATA, STOP):
- IDLE: wait for synchronized rx = 0, then go to START.
- START: at CLKS_PER_BIT/2 cycles, re-sample.
  - If high: false start, return to IDLE, no outputs.
  - If low: go to DATA.
- DATA: sample every CLKS_PER_BIT cycles (mid-bit), shift in LSB first; 8 samples, then STOP.
- STOP: sample mid-bit.
  - If 1: rx_data ← shift register, rx_done=1 for one cycle.
  - If 0: frame_err=1 for one cycle, rx_data unchanged.
  - Either way return to IDLE on the following cycle. RX can then detect a back-to-back start bit immediately.

Latency:
- Loopback, start sampled to rx_done: 9*CLKS_PER_BIT + CLKS_PER_BIT/2 + 4 cycles, ±1.
- The verifier accepts that window.

Other rules:
- rx_done and frame_err are never high together.
- Counters are sized $clog2(CLKS_PER_BIT) bits and reset to 0 on every state change.

Optional Feature:
UART_PARITY_EN:
- Defined: an even-parity bit is inserted between data bit 7 and the stop bit, on both TX and RX.
  - RX compares received parity against XOR of the data bits.
  - On mismatch, asserts frame_err (one cycle) instead of rx_done; rx_data is unchanged.
  - Latency grows by CLKS_PER_BIT.
- Undefined: pure 8N1 as above. The parity states are not compiled in.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP) shared by TX and RX
  - DATA_BITS=8 constant
  - IDLE_LEVEL=1'b1 constant
- One sub-module, uart_rx_unit, contains the synchronizer, RX FSM and RX counters.
- The TX path is implemented inline in uart_core.

Test Plan (CLKS_PER_BIT=16, 20 ns clock, tx looped to rx):
- Reset held 5 cycles → tx=1, tx_busy=0, rx_data=8'h00, rx_done=0 throughout.
- start pulse with tx_data=8'hA5:
  - tx low for 16 cycles, then bits 1,0,1,0,0,1,0,1, then high 16 cycles.
  - rx_done single pulse with rx_data=8'hA5.
- Back-to-back bytes 8'h00 then 8'hFF, second start issued on first IDLE cycle → two rx_done pulses, values 00 then FF; tx_busy low for exactly one cycle between frames.
- start pulsed mid-frame with tx_data=8'h3C during 8'h81 transmission → only 8'h81 received; no extra frame.
- rx driven (loopback broken) low for 5 cycles then high → no rx_done, no frame_err, RX back in IDLE.
- rx frame 8'h55 with stop bit forced 0 → frame_err one-cycle pulse, no rx_done, rx_data keeps previous value; rst asserted mid-frame → all outputs return to reset values next cycle.
